// File: rtl/wb_io_regbank.sv
// Wishbone I/O register bank: NREGS 16-bit registers at consecutive word ports,
// byte-lane access, programmable wait states and one-cycle per-register write strobes.
module wb_io_regbank #(
    parameter int unsigned NREGS        = 4,
    parameter logic [15:0] BASE         = 16'h00b0,
    parameter int unsigned WAIT         = 0,
    parameter logic [15:0] RESET_VAL    = 16'h0000,
    parameter bit          ACK_UNMAPPED = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           adr_i,
    input  logic [15:0]           dat_i,
    output logic [15:0]           dat_o,
    input  logic                  we_i,
    input  logic                  byte_i,
    input  logic                  stb_i,
    output logic                  ack_o,
    output logic [16*NREGS-1:0]   regs_o,
    output logic [NREGS-1:0]      wr_stb_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAITST = 2'd1, ACK = 2'd2} state_t;

    localparam logic [16:0] SPAN    = 17'(2 * NREGS);
    localparam logic [2:0]  WAIT_LD = 3'(WAIT);
    localparam bit          NO_WAIT = (WAIT == 0);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        hit_q;
    logic        we_q;
    logic        byte_q;
    logic        lane_q;
    logic [3:0]  idx_q;
    logic [15:0] dat_q;
    logic [15:0] regs_q [NREGS];

    logic [15:0]      off_s;
    logic             hit_s;
    logic             start_s;
    logic             commit_s;
    logic             w_hit_s;
    logic             w_we_s;
    logic             w_byte_s;
    logic             w_lane_s;
    logic [3:0]       w_idx_s;
    logic [15:0]      w_dat_s;
    logic [15:0]      rd_word_s;
    logic [15:0]      rd_s;
    logic [NREGS-1:0] ack_wsel_s;

    function automatic logic [15:0] lane_write(input logic [15:0] cur, input logic [15:0] wd,
                                               input logic is_byte, input logic hi);
        logic [15:0] res;
        if (!is_byte) begin
            res = wd;
        end else if (hi) begin
            res = {wd[7:0], cur[7:0]};
        end else begin
            res = {cur[15:8], wd[7:0]};
        end
        return res;
    endfunction

    function automatic logic [15:0] lane_read(input logic [15:0] cur, input logic is_byte,
                                              input logic hi);
        logic [15:0] res;
        if (!is_byte) begin
            res = cur;
        end else if (hi) begin
            res = {8'h00, cur[15:8]};
        end else begin
            res = {8'h00, cur[7:0]};
        end
        return res;
    endfunction

    // Address decode of the live bus request.
    always_comb begin
        off_s   = adr_i - BASE;
        hit_s   = (adr_i >= BASE) && ({1'b0, off_s} < SPAN);
        start_s = stb_i && (hit_s || ACK_UNMAPPED);
    end

    // Zero-wait writes commit on the sampling edge, so they take the live bus values.
    always_comb begin
        if (state_q == IDLE) begin
            w_hit_s  = hit_s;
            w_idx_s  = off_s[4:1];
            w_we_s   = we_i;
            w_byte_s = byte_i;
            w_lane_s = adr_i[0];
            w_dat_s  = dat_i;
        end else begin
            w_hit_s  = hit_q;
            w_idx_s  = idx_q;
            w_we_s   = we_q;
            w_byte_s = byte_q;
            w_lane_s = lane_q;
            w_dat_s  = dat_q;
        end
        commit_s = ((state_q == IDLE) && start_s && NO_WAIT) ||
                   ((state_q == WAITST) && (cnt_q == 3'd1));
    end

    // Read mux and write-strobe select for the captured transfer.
    always_comb begin
        rd_word_s  = 16'h0000;
        ack_wsel_s = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (hit_q && (idx_q == 4'(k))) begin
                rd_word_s     = regs_q[k];
                ack_wsel_s[k] = we_q;
            end else begin
                ack_wsel_s[k] = 1'b0;
            end
        end
        rd_s = lane_read(rd_word_s, byte_q, lane_q);
    end

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
            assign regs_o[16*g +: 16] = regs_q[g];
        end
    endgenerate

    // Transfer FSM, registered bus outputs and the register array.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            hit_q    <= 1'b0;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            lane_q   <= 1'b0;
            idx_q    <= 4'd0;
            dat_q    <= 16'h0000;
            ack_o    <= 1'b0;
            dat_o    <= 16'h0000;
            wr_stb_o <= '0;
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else begin
            ack_o    <= 1'b0;
            dat_o    <= 16'h0000;
            wr_stb_o <= '0;
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        hit_q  <= hit_s;
                        idx_q  <= off_s[4:1];
                        we_q   <= we_i;
                        byte_q <= byte_i;
                        lane_q <= adr_i[0];
                        dat_q  <= dat_i;
                        if (NO_WAIT) begin
                            state_q <= ACK;
                        end else begin
                            cnt_q   <= WAIT_LD;
                            state_q <= WAITST;
                        end
                    end
                end
                WAITST: begin
                    if (cnt_q == 3'd1) begin
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ACK: begin
                    ack_o    <= 1'b1;
                    dat_o    <= we_q ? 16'h0000 : rd_s;
                    wr_stb_o <= ack_wsel_s;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (commit_s && w_hit_s && w_we_s) begin
                for (int k = 0; k < NREGS; k++) begin
                    if (w_idx_s == 4'(k)) begin
                        regs_q[k] <= lane_write(regs_q[k], w_dat_s, w_byte_s, w_lane_s);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_io_regbank.sv
// Bench for wb_io_regbank: three parameterisations checked every cycle against a
// transaction-level model (accept edge + wait count -> commit/ack edges), plus directed cases.
module tb_wb_io_regbank;
    localparam int          NI   = 3;
    localparam logic [15:0] BASE = 16'h00b0;
    localparam int          W0 = 1, W1 = 3, W2 = 0;
    localparam int          N0 = 4, N1 = 4, N2 = 2;
    localparam logic [15:0] RV0 = 16'h0000, RV1 = 16'hC3A5, RV2 = 16'h0F0F;
    localparam bit          U0 = 1'b1, U1 = 1'b1, U2 = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        stb  [NI];
    logic        we   [NI];
    logic        byt  [NI];
    logic [15:0] adr  [NI];
    logic [15:0] wdat [NI];
    logic        ack  [NI];
    logic [15:0] rdat [NI];
    logic [63:0] regs_a, regs_b;
    logic [31:0] regs_c;
    logic [3:0]  ws_a, ws_b;
    logic [1:0]  ws_c;
    logic [15:0] dregs [NI][16];
    logic [15:0] dws   [NI];

    int n_cmp = 0;
    int n_bad = 0;

    wb_io_regbank #(.NREGS(N0), .BASE(BASE), .WAIT(W0), .RESET_VAL(RV0), .ACK_UNMAPPED(U0)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .adr_i(adr[0]), .dat_i(wdat[0]), .dat_o(rdat[0]),
        .we_i(we[0]), .byte_i(byt[0]), .stb_i(stb[0]), .ack_o(ack[0]),
        .regs_o(regs_a), .wr_stb_o(ws_a));
    wb_io_regbank #(.NREGS(N1), .BASE(BASE), .WAIT(W1), .RESET_VAL(RV1), .ACK_UNMAPPED(U1)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .adr_i(adr[1]), .dat_i(wdat[1]), .dat_o(rdat[1]),
        .we_i(we[1]), .byte_i(byt[1]), .stb_i(stb[1]), .ack_o(ack[1]),
        .regs_o(regs_b), .wr_stb_o(ws_b));
    wb_io_regbank #(.NREGS(N2), .BASE(BASE), .WAIT(W2), .RESET_VAL(RV2), .ACK_UNMAPPED(U2)) dut_c (
        .clk_i(clk), .rst_i(rst_n), .adr_i(adr[2]), .dat_i(wdat[2]), .dat_o(rdat[2]),
        .we_i(we[2]), .byte_i(byt[2]), .stb_i(stb[2]), .ack_o(ack[2]),
        .regs_o(regs_c), .wr_stb_o(ws_c));

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 16; k++) begin
                dregs[i][k] = 16'h0000;
            end
        end
        for (int k = 0; k < 4; k++) begin
            dregs[0][k] = regs_a[16*k +: 16];
            dregs[1][k] = regs_b[16*k +: 16];
        end
        for (int k = 0; k < 2; k++) begin
            dregs[2][k] = regs_c[16*k +: 16];
        end
        dws[0] = {12'h000, ws_a};
        dws[1] = {12'h000, ws_b};
        dws[2] = {14'h0000, ws_c};
    end

    function automatic int wt(input int i);
        return (i == 0) ? W0 : (i == 1) ? W1 : W2;
    endfunction
    function automatic int nr(input int i);
        return (i == 0) ? N0 : (i == 1) ? N1 : N2;
    endfunction
    function automatic logic [15:0] rv(input int i);
        return (i == 0) ? RV0 : (i == 1) ? RV1 : RV2;
    endfunction
    function automatic bit um(input int i);
        return (i == 0) ? U0 : (i == 1) ? U1 : U2;
    endfunction
    function automatic bit bhit(input int i, input logic [15:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) - int'(BASE) < 2 * nr(i));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one pending transfer per bank, stamped with commit and ack edges.
    typedef struct {
        bit          v;
        int          ce;
        int          ae;
        bit          hit;
        int          idx;
        bit          we;
        bit          byt;
        bit          lane;
        logic [15:0] d;
    } txn_t;

    txn_t        pend  [NI];
    logic [15:0] mreg  [NI][16];
    bit          e_ack [NI];
    bit          e_we  [NI];
    logic [15:0] e_dat [NI];
    logic [15:0] e_ws  [NI];
    int          ecnt;

    task automatic mreset();
        for (int i = 0; i < NI; i++) begin
            pend[i].v = 1'b0;
            e_ack[i]  = 1'b0;
            e_we[i]   = 1'b0;
            e_dat[i]  = 16'h0000;
            e_ws[i]   = 16'h0000;
            for (int k = 0; k < 16; k++) mreg[i][k] = rv(i);
        end
    endtask

    task automatic mstep(input int i);
        logic [15:0] cur;
        e_ack[i] = 1'b0;
        e_we[i]  = 1'b0;
        e_dat[i] = 16'h0000;
        e_ws[i]  = 16'h0000;
        if (pend[i].v && pend[i].ae == ecnt) begin
            e_ack[i] = 1'b1;
            e_we[i]  = pend[i].we;
            if (pend[i].hit) begin
                cur = mreg[i][pend[i].idx];
                if (pend[i].we) e_ws[i] = 16'h0001 << pend[i].idx;
                else if (!pend[i].byt) e_dat[i] = cur;
                else e_dat[i] = pend[i].lane ? {8'h00, cur[15:8]} : {8'h00, cur[7:0]};
            end
            pend[i].v = 1'b0;
        end else if (!pend[i].v && stb[i] && (bhit(i, adr[i]) || um(i))) begin
            pend[i].v    = 1'b1;
            pend[i].ce   = ecnt + wt(i);
            pend[i].ae   = ecnt + wt(i) + 1;
            pend[i].hit  = bhit(i, adr[i]);
            pend[i].idx  = (int'(adr[i]) - int'(BASE)) / 2;
            pend[i].we   = we[i];
            pend[i].byt  = byt[i];
            pend[i].lane = adr[i][0];
            pend[i].d    = wdat[i];
        end
        if (pend[i].v && pend[i].ce == ecnt && pend[i].we && pend[i].hit) begin
            cur = mreg[i][pend[i].idx];
            if (!pend[i].byt) mreg[i][pend[i].idx] = pend[i].d;
            else if (pend[i].lane) mreg[i][pend[i].idx] = {pend[i].d[7:0], cur[7:0]};
            else mreg[i][pend[i].idx] = {cur[15:8], pend[i].d[7:0]};
        end
    endtask

    initial begin
        ecnt = 0;
        mreset();
        forever begin
            @(posedge clk);
            ecnt++;
            if (!rst_n) mreset();
            else for (int i = 0; i < NI; i++) mstep(i);
        end
    end

    // Per-cycle comparison of every bank against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("i%0d ack_o", i), 32'(ack[i]), 32'(rst_n ? e_ack[i] : 1'b0));
                chk($sformatf("i%0d wr_stb_o", i), 32'(dws[i]), 32'(rst_n ? e_ws[i] : 16'h0000));
                if (!(rst_n && e_ack[i] && e_we[i]))
                    chk($sformatf("i%0d dat_o", i), 32'(rdat[i]), 32'(rst_n ? e_dat[i] : 16'h0000));
                for (int k = 0; k < nr(i); k++)
                    chk($sformatf("i%0d reg%0d", i, k), 32'(dregs[i][k]),
                        32'(rst_n ? mreg[i][k] : rv(i)));
            end
        end
    end

    task automatic xfer(input int i, input bit w, input bit b, input logic [15:0] a,
                        input logic [15:0] d, output bit got, output logic [15:0] rd,
                        output int lat, output logic [15:0] ws);
        stb[i] = 1'b1; we[i] = w; byt[i] = b; adr[i] = a; wdat[i] = d;
        got = 1'b0; rd = 16'h0000; lat = 0; ws = 16'h0000;
        while (!got && lat < 20) begin
            @(posedge clk); #2;
            lat++;
            if (ack[i]) begin
                got = 1'b1;
                rd  = rdat[i];
                ws  = dws[i];
            end
        end
        stb[i] = 1'b0; we[i] = 1'b0;
    endtask

    initial begin
        bit          got;
        bit          w;
        bit          b;
        logic [15:0] rd;
        logic [15:0] ws;
        logic [15:0] a;
        int          lat;
        int          sel;
        int          nack;
        int          nws;
        int          first;
        int          second;

        for (int i = 0; i < NI; i++) begin
            stb[i] = 1'b0; we[i] = 1'b0; byt[i] = 1'b0; adr[i] = 16'h0000; wdat[i] = 16'h0000;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("reset inst1 reg1", 32'(dregs[1][1]), 32'h0000C3A5);
        chk("reset inst2 reg0", 32'(dregs[2][0]), 32'h00000F0F);

        // Word write with one wait state.
        xfer(0, 1'b1, 1'b0, 16'h00b2, 16'h1234, got, rd, lat, ws);
        chk("t1 ack", 32'(got), 32'h1);
        chk("t1 latency", 32'(lat - 1), 32'h2);
        chk("t1 wr_stb", 32'(ws), 32'h2);
        chk("t1 reg1", 32'(dregs[0][1]), 32'h1234);
        @(posedge clk); #2;
        chk("t1 ack width", 32'(ack[0]), 32'h0);

        // Byte writes, high lane then low lane; upper data byte must be ignored.
        xfer(0, 1'b1, 1'b1, 16'h00b3, 16'h55AB, got, rd, lat, ws);
        chk("t2 hi byte", 32'(dregs[0][1]), 32'hAB34);
        xfer(0, 1'b1, 1'b1, 16'h00b2, 16'h66CD, got, rd, lat, ws);
        chk("t2 lo byte", 32'(dregs[0][1]), 32'hABCD);

        xfer(0, 1'b0, 1'b0, 16'h00b2, 16'h0000, got, rd, lat, ws);
        chk("t3 word rd", 32'(rd), 32'hABCD);
        xfer(0, 1'b0, 1'b1, 16'h00b3, 16'h0000, got, rd, lat, ws);
        chk("t3 byte rd hi", 32'(rd), 32'h00AB);
        xfer(0, 1'b0, 1'b1, 16'h00b2, 16'h0000, got, rd, lat, ws);
        chk("t3 byte rd lo", 32'(rd), 32'h00CD);
        @(posedge clk); #2;
        chk("t3 dat idle", 32'(rdat[0]), 32'h0);

        // Unmapped port, acknowledged and ignored flavours.
        xfer(0, 1'b0, 1'b0, 16'h0060, 16'h0000, got, rd, lat, ws);
        chk("t4 unm ack", 32'(got), 32'h1);
        chk("t4 unm rd", 32'(rd), 32'h0);
        xfer(0, 1'b1, 1'b0, 16'h0060, 16'hFFFF, got, rd, lat, ws);
        chk("t4 unm wr ack", 32'(got), 32'h1);
        chk("t4 unm wr_stb", 32'(ws), 32'h0);
        chk("t4 reg1 kept", 32'(dregs[0][1]), 32'hABCD);
        chk("t4 reg0 kept", 32'(dregs[0][0]), 32'h0);
        xfer(2, 1'b0, 1'b0, 16'h0060, 16'h0000, got, rd, lat, ws);
        chk("t4 unm ignored", 32'(got), 32'h0);
        xfer(2, 1'b1, 1'b0, 16'h00b2, 16'hBEEF, got, rd, lat, ws);
        chk("t4 nowait latency", 32'(lat - 1), 32'h1);
        chk("t4 nowait reg1", 32'(dregs[2][1]), 32'hBEEF);

        // Reset during wait states aborts the write.
        stb[1] = 1'b1; we[1] = 1'b1; byt[1] = 1'b0; adr[1] = 16'h00b0; wdat[1] = 16'h5555;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5 ack in reset", 32'(ack[1]), 32'h0);
        chk("t5 reg0 reset", 32'(dregs[1][0]), 32'h0000C3A5);
        stb[1] = 1'b0; we[1] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        nack = 0;
        repeat (8) begin
            @(posedge clk); #2;
            if (ack[1]) nack++;
        end
        chk("t5 no ack", 32'(nack), 32'h0);
        chk("t5 reg0 after", 32'(dregs[1][0]), 32'h0000C3A5);
        xfer(1, 1'b0, 1'b0, 16'h00b0, 16'h0000, got, rd, lat, ws);
        chk("t5 post rd", 32'(rd), 32'h0000C3A5);
        chk("t5 post latency", 32'(lat - 1), 32'h4);
        xfer(1, 1'b1, 1'b0, 16'h00b0, 16'h5555, got, rd, lat, ws);
        chk("t5 post wr", 32'(dregs[1][0]), 32'h5555);

        // Strobe held across the ack repeats the write.
        stb[0] = 1'b1; we[0] = 1'b1; byt[0] = 1'b0; adr[0] = 16'h00b6; wdat[0] = 16'h7E57;
        nack = 0; nws = 0; first = 0; second = 0;
        for (int c = 0; c < 30 && nack < 2; c++) begin
            @(posedge clk); #2;
            if (ack[0]) begin
                nack++;
                if (dws[0][3]) nws++;
                if (nack == 1) first = c;
                else second = c;
            end
        end
        stb[0] = 1'b0; we[0] = 1'b0;
        chk("t6 acks", 32'(nack), 32'h2);
        chk("t6 wr_stb3", 32'(nws), 32'h2);
        chk("t6 gap", 32'(second - first - 1), 32'h2);
        chk("t6 reg3", 32'(dregs[0][3]), 32'h7E57);

        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 50; n++) begin
                sel = $urandom_range(0, 9);
                if (sel < 7) a = BASE - 16'd2 + 16'($urandom_range(0, 2 * nr(i) + 3));
                else if (sel < 8) a = 16'h0060;
                else a = 16'($urandom);
                w = 1'($urandom_range(0, 1));
                b = 1'($urandom_range(0, 1));
                xfer(i, w, b, a, 16'($urandom), got, rd, lat, ws);
                chk($sformatf("rnd i%0d ack", i), 32'(got), 32'(bhit(i, a) || um(i)));
                if (got) chk($sformatf("rnd i%0d latency", i), 32'(lat - 1), 32'(wt(i) + 1));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #2;
                end
            end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_io_regbank.md
Name: wb_io_regbank

Overview:
Parametrised Wishbone I/O register bank, successor to the single-port I/O stub at the board top level. It provides NREGS 16-bit read/write registers at consecutive word-aligned I/O ports, with byte-lane writes and readback. It adds configurable wait states and one-cycle write-strobe outputs per register. Unmapped ports can optionally be acknowledged so the CPU never hangs. It sits on the CPU I/O bus, with stb_i already qualified by mio.

Parameters:
NREGS, 4, number of 16-bit registers (1..16)
BASE, 16'h00b0, I/O port of register 0; must be even
WAIT, 0, wait states inserted before ack (0..7)
RESET_VAL, 16'h0000, reset value of every register
ACK_UNMAPPED, 1, 1 = acknowledge unmapped ports with read data 0; 0 = ignore them

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
adr_i  in  16  I/O port address
dat_i  in  16  write data
dat_o  out  16  read data, valid while ack_o=1
we_i  in  1  1 = write
byte_i  in  1  1 = byte access, 0 = word access
stb_i  in  1  I/O strobe (CPU stb & mio)
ack_o  out  1  transfer acknowledge, one-cycle pulse
regs_o  out  16*NREGS  register contents; reg k at [16k+15:16k]
wr_stb_o  out  NREGS  one-cycle pulse when reg k is written

Behaviour:
- Hit: BASE <= adr_i <= BASE+2*NREGS-1. Index k = (adr_i-BASE)>>1. adr_i[0] selects the byte lane for byte access and is ignored for word access.
- Reset (rst_i low, asynchronous): state IDLE, ack_o=0, dat_o=0, wr_stb_o=0, all registers = RESET_VAL. Any transfer in flight is aborted with no write and no ack.
- FSM states IDLE, WAITST, ACK:
  - IDLE: on a rising edge with stb_i=1 and (hit or ACK_UNMAPPED=1), capture adr_i, we_i, byte_i and dat_i. Go to ACK if WAIT=0, else load the counter with WAIT and go to WAITST.
  - IDLE with stb_i=1, no hit and ACK_UNMAPPED=0: stay in IDLE, no response.
  - WAITST: decrement the counter each clock; go to ACK when the counter reaches 1.
  - ACK: ack_o=1 for exactly one cycle, then go to IDLE.
- Latency: ack_o rises WAIT+1 clocks after the edge that sampled the strobe.
- stb_i still high in the IDLE cycle after ACK starts a new transfer. The CPU must drop stb_i in the ack cycle to avoid a repeat.
- Writes use the captured values and commit on the edge that enters ACK, so the registers are updated when ack_o=1:
  - Word write: reg[k] = data.
  - Byte write, even port: reg[k][7:0] = data[7:0].
  - Byte write, odd port: reg[k][15:8] = data[7:0].
  - wr_stb_o[k] pulses high in the ACK cycle.
- Reads: dat_o is registered and valid in the ACK cycle, and 0 in all other cycles.
  - Word read: reg[k].
  - Byte read, even port: {8'h00, reg[k][7:0]}.
  - Byte read, odd port: {8'h00, reg[k][15:8]}.
  - Unmapped port: 16'h0000.
- Writes to unmapped ports are acknowledged (when ACK_UNMAPPED=1) but discarded; no wr_stb_o pulse.
- stb_i dropping during WAITST does not cancel the transfer; the ack is still issued.
- regs_o is driven combinationally from the register array.

Test Plan:
1. WAIT=1: word write 16'h1234 to 16'h00b2 -> ack_o high 2 clocks after the sampling edge, for exactly 1 cycle. regs_o[31:16]=16'h1234, wr_stb_o=4'b0010 in the ack cycle.
2. Byte write 8'hAB to 16'h00b3 (reg1 = 16'h1234) -> reg1=16'hAB34. Then byte write 8'hCD to 16'h00b2 -> reg1=16'hABCD.
3. Reads of reg1=16'hABCD -> word read of 00b2 returns 16'hABCD; byte read of 00b3 returns 16'h00AB; byte read of 00b2 returns 16'h00CD. dat_o=0 outside the ack cycle.
4. Unmapped port 16'h0060: with ACK_UNMAPPED=1 a read -> ack_o pulse, dat_o=0, and a write leaves all registers unchanged. With ACK_UNMAPPED=0 -> no ack within 20 clocks and the FSM stays in IDLE.
5. WAIT=3, word write 16'h5555 to 16'h00b0, rst_i pulsed low during WAITST -> ack_o=0 immediately, never pulses, all registers = RESET_VAL. A transfer issued after reset completes normally.
6. stb_i held high across the ack with a write to 16'h00b6 -> two writes and two ack pulses. The ack pulses are separated by WAIT+1 idle clocks, and wr_stb_o[3] pulses twice.
